// File: rtl/step_controller.sv
// Single-step / run controller for a multicycle datapath: debounced step key and
// run switch, free-running step divider, breakpoint/halt handling and a step counter.
module step_controller #(
    parameter int DB_CYCLES = 16,
    parameter int RUN_DIV   = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        key_step,
    input  logic        sw_run,
    input  logic        halt_req,
    input  logic [7:0]  pc,
    input  logic [7:0]  bp_addr,
    input  logic        bp_en,
    output logic        step_pulse,
    output logic [1:0]  state,
    output logic        halted,
    output logic [15:0] step_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        HALTED = 2'b10
    } state_t;

    localparam int         DB_W    = $clog2(DB_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_MAX  = DB_W'(DB_CYCLES - 1);
    localparam logic [7:0] RUN_MAX = 8'(RUN_DIV - 1);

    state_t          state_q, state_d;
    logic            pulse_d;
    logic            key_s1, key_s2, key_db, key_db_prev;
    logic            run_s1, run_s2, run_db;
    logic [DB_W-1:0] key_cnt, run_cnt;
    logic [7:0]      div_q;
    logic            press;
    logic            halt_cond;

    // NOTE: every flop uses non-blocking assignment so all registers update
    // from the same pre-edge values, independent of block ordering.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            key_s1 <= 1'b1;
            key_s2 <= 1'b1;
            run_s1 <= 1'b0;
            run_s2 <= 1'b0;
        end else begin
            key_s1 <= key_step;
            key_s2 <= key_s1;
            run_s1 <= sw_run;
            run_s2 <= run_s1;
        end
    end

    // A debounced copy flips only after DB_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            key_db      <= 1'b1;
            key_db_prev <= 1'b1;
            key_cnt     <= '0;
        end else begin
            key_db_prev <= key_db;
            if (key_s2 == key_db) begin
                key_cnt <= '0;
            end else if (key_cnt == DB_MAX) begin
                key_db  <= key_s2;
                key_cnt <= '0;
            end else begin
                key_cnt <= key_cnt + DB_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            run_db  <= 1'b0;
            run_cnt <= '0;
        end else if (run_s2 == run_db) begin
            run_cnt <= '0;
        end else if (run_cnt == DB_MAX) begin
            run_db  <= run_s2;
            run_cnt <= '0;
        end else begin
            run_cnt <= run_cnt + DB_W'(1);
        end
    end

    assign press     = key_db_prev & ~key_db;
    assign halt_cond = halt_req | (bp_en & (pc == bp_addr));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            step_pulse <= 1'b0;
            halted     <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_pulse <= pulse_d;
            halted     <= (state_d == HALTED);
        end
    end

    // NOTE: defaults at the top of each combinational block keep every path
    // assigned, so no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (run_db) state_d = RUN;
            RUN:     if (halt_cond) state_d = HALTED;
                     else if (!run_db) state_d = IDLE;
            HALTED:  if (press) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Halt and run-switch release both suppress the divider pulse.
    always_comb begin
        pulse_d = 1'b0;
        unique case (state_q)
            IDLE:    pulse_d = press;
            RUN:     pulse_d = !halt_cond && run_db && (div_q == RUN_MAX);
            HALTED:  pulse_d = press;
            default: pulse_d = 1'b0;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            div_q      <= '0;
            step_count <= '0;
        end else begin
            if (state_q != RUN || state_d != RUN)
                div_q <= '0;
            else if (div_q == RUN_MAX)
                div_q <= '0;
            else
                div_q <= div_q + 8'd1;
            if (step_pulse)
                step_count <= step_count + 16'd1;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_step_controller.sv
// Directed bench for step_controller: key latency, bounce rejection, run divider,
// breakpoint/halt priority, counter wrap and mid-run reset.
module tb_step_controller;

    logic        clock;
    logic        reset;
    logic        key_step;
    logic        sw_run;
    logic        halt_req;
    logic [7:0]  pc;
    logic [7:0]  bp_addr;
    logic        bp_en;
    logic        step_pulse;
    logic [1:0]  state;
    logic        halted;
    logic [15:0] step_count;

    int checks = 0;
    int errors = 0;
    int exp_count = 0;
    int p;

    step_controller #(.DB_CYCLES(16), .RUN_DIV(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .key_step   (key_step),
        .sw_run     (sw_run),
        .halt_req   (halt_req),
        .pc         (pc),
        .bp_addr    (bp_addr),
        .bp_en      (bp_en),
        .step_pulse (step_pulse),
        .state      (state),
        .halted     (halted),
        .step_count (step_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic count_pulses(input int n, output int pulses);
        pulses = 0;
        repeat (n) begin
            tick();
            if (step_pulse) pulses++;
        end
    endtask

    // Press held from the current cycle: pulse exactly 19 cycles later, then count+1.
    task automatic press_and_check(input string tag);
        int q;
        key_step = 1'b0;
        count_pulses(18, q);
        check({tag, "_early"}, q, 0);
        tick();
        check({tag, "_pulse"}, step_pulse, 1);
        check({tag, "_state"}, state, 2'b00);
        exp_count++;
        tick();
        check({tag, "_pulse_off"}, step_pulse, 0);
        check({tag, "_count"}, step_count, exp_count);
    endtask

    initial begin
        reset    = 1'b0;
        key_step = 1'b1;
        sw_run   = 1'b0;
        halt_req = 1'b0;
        pc       = 8'h00;
        bp_addr  = 8'h05;
        bp_en    = 1'b0;
        repeat (3) tick();
        check("rst_state", state, 2'b00);
        check("rst_pulse", step_pulse, 0);
        check("rst_halted", halted, 0);
        check("rst_count", step_count, 0);
        reset = 1'b1;

        count_pulses(30, p);
        check("idle_quiet", p, 0);

        // Single step from IDLE, then release produces nothing.
        tick();
        press_and_check("key1");
        key_step = 1'b1;
        count_pulses(40, p);
        check("release_quiet", p, 0);

        // Bounce: 5-cycle phases never reach 16 stable samples.
        for (int i = 0; i < 20; i++) begin
            key_step = ~key_step;
            count_pulses(5, p);
            check("bounce", p, 0);
        end
        key_step = 1'b1;
        count_pulses(30, p);
        check("bounce_tail", p, 0);
        check("bounce_count", step_count, exp_count);

        // Run mode: RUN 19 cycles after sw_run, then a pulse every 4th cycle.
        sw_run = 1'b1;
        count_pulses(18, p);
        check("run_pre_state", state, 2'b00);
        check("run_pre_pulse", p, 0);
        tick();
        check("run_entry", state, 2'b01);
        for (int i = 1; i <= 40; i++) begin
            tick();
            check("run_pulse", step_pulse, (i % 4 == 0) ? 1 : 0);
        end
        exp_count += 10;
        tick();
        check("run_count", step_count, exp_count);

        // Breakpoint hit on the divider's terminal count: halt wins, no pulse.
        bp_en = 1'b1;
        tick();
        tick();
        check("bp_pre_pulse", step_pulse, 0);
        pc = 8'h05;
        tick();
        check("bp_pulse", step_pulse, 0);
        check("bp_state", state, 2'b10);
        check("bp_halted", halted, 1);

        // Everything but a press is ignored while HALTED.
        sw_run   = 1'b0;
        halt_req = 1'b1;
        count_pulses(30, p);
        check("halted_quiet", p, 0);
        check("halted_hold", state, 2'b10);
        check("halted_count", step_count, exp_count);
        press_and_check("bp_step");
        check("bp_step_halted", halted, 0);
        key_step = 1'b1;
        halt_req = 1'b0;
        bp_en    = 1'b0;
        pc       = 8'h00;
        count_pulses(25, p);
        check("bp_release_quiet", p, 0);

        // halt_req on the terminal count also halts without a pulse.
        sw_run = 1'b1;
        repeat (19) tick();
        check("run2_entry", state, 2'b01);
        repeat (3) tick();
        halt_req = 1'b1;
        tick();
        check("halt_pulse", step_pulse, 0);
        check("halt_state", state, 2'b10);
        halt_req = 1'b0;
        sw_run   = 1'b0;
        repeat (25) tick();
        check("halt_hold", state, 2'b10);
        press_and_check("halt_step");
        key_step = 1'b1;
        repeat (25) tick();

        // Counter wrap: preset to 0xFFFF, one run pulse rolls it to 0.
        force dut.step_count = 16'hFFFF;
        tick();
        release dut.step_count;
        tick();
        sw_run = 1'b1;
        repeat (19) tick();
        check("run3_entry", state, 2'b01);
        repeat (4) tick();
        check("wrap_pulse", step_pulse, 1);
        tick();
        check("wrap_count", step_count, 16'h0000);

        // Asynchronous reset mid-RUN clears outputs before the next edge.
        #3;
        reset = 1'b0;
        #1;
        check("async_state", state, 2'b00);
        check("async_pulse", step_pulse, 0);
        check("async_halted", halted, 0);
        check("async_count", step_count, 0);
        sw_run   = 1'b0;
        key_step = 1'b0;
        repeat (3) tick();

        // Key held through reset still needs the full latency after release.
        exp_count = 0;
        reset = 1'b1;
        press_and_check("post_reset");
        key_step = 1'b1;
        count_pulses(25, p);
        check("final_quiet", p, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
